// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-port round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  localparam int CNT_W = 8;

  // Grant state that corresponds to a given port number.
  function automatic arb_state_t gnt_of(input logic port);
    return port ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// Valid/ready output register holding one muxed beat for the downstream sink.
module mux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic [WIDTH-1:0] d,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  // Load on accept, otherwise drop the beat once the sink has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (acc) begin
      valid_o <= 1'b1;
      data_o  <= d;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with a beat quantum, driving a 2:1 mux
// into a registered valid/ready output stage.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int QUANTUM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  output logic             ready0_o,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             ready1_o,
  output logic             sel_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);

  // Count value of the last beat a grant may take while the other side waits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_state_t       oth_gnt;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             room;
  logic             acc;
  logic             own_req;
  logic             oth_req;
  logic [WIDTH-1:0] mux_d;

  // The output stage can take a beat when empty or draining this cycle.
  assign room     = !valid_o || ready_i;
  assign ready0_o = (state == GNT0) && room;
  assign ready1_o = (state == GNT1) && room;
  assign acc      = (req0_i && ready0_o) || (req1_i && ready1_o);
  assign mux_d    = (sel_o == SEL_I1) ? data1_i : data0_i;

  // Next grant and beat count; any change of owner restarts the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    own_req   = (state == GNT1) ? req1_i : req0_i;
    oth_req   = (state == GNT1) ? req0_i : req1_i;
    oth_gnt   = (state == GNT1) ? GNT0 : GNT1;
    case (state)
      IDLE: begin
        if (req0_i && req1_i) state_nxt = gnt_of(ptr);
        else if (req0_i)      state_nxt = GNT0;
        else if (req1_i)      state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_req) begin
          state_nxt = oth_req ? oth_gnt : IDLE;
        end else if (acc && (cnt == CNT_LAST)) begin
          if (oth_req) state_nxt = oth_gnt;
          else         cnt_nxt   = '0;
        end else if (acc) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Grant state, tie-break pointer and mux select; select holds through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
      sel_o <= SEL_I0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == GNT0) begin
        ptr   <= 1'b1;
        sel_o <= SEL_I0;
      end else if (state_nxt == GNT1) begin
        ptr   <= 1'b0;
        sel_o <= SEL_I1;
      end
    end
  end

  mux_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc),
    .d       (mux_d),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: each row applies inputs for the next
// edge and checks the outputs after the previous edge.
module tb_mux_rr_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [7:0] data0;
  logic       ready0;
  logic       req1;
  logic [7:0] data1;
  logic       ready1;
  logic       sel;
  logic       valid;
  logic [7:0] dout;
  logic       rdy;

  int n_tests;
  int n_fail;
  int row;

  mux_rr_arbiter #(
    .WIDTH   (8),
    .QUANTUM (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (req0),
    .data0_i  (data0),
    .ready0_o (ready0),
    .req1_i   (req1),
    .data1_i  (data1),
    .ready1_o (ready1),
    .sel_o    (sel),
    .valid_o  (valid),
    .data_o   (dout),
    .ready_i  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: wait for the edge, apply new inputs, check outputs.
  task automatic cyc(input logic r0, input logic [7:0] d0, input logic r1,
                     input logic [7:0] d1, input logic rd,
                     input logic e_r0, input logic e_r1, input logic e_sel,
                     input logic e_v, input logic [7:0] e_d);
    @(posedge clk);
    #1;
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
    rdy   = rd;
    #1;
    row++;
    chk($sformatf("row%0d ready0", row), 32'(ready0), 32'(e_r0));
    chk($sformatf("row%0d ready1", row), 32'(ready1), 32'(e_r1));
    chk($sformatf("row%0d sel", row),    32'(sel),    32'(e_sel));
    chk($sformatf("row%0d valid", row),  32'(valid),  32'(e_v));
    chk($sformatf("row%0d data", row),   32'(dout),   32'(e_d));
  endtask

  // Mid-cycle asynchronous reset pulse, released on a falling edge.
  task automatic do_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    chk({tag, " rst ready0"}, 32'(ready0), 32'd0);
    chk({tag, " rst ready1"}, 32'(ready1), 32'd0);
    chk({tag, " rst sel"},    32'(sel),    32'd0);
    chk({tag, " rst valid"},  32'(valid),  32'd0);
    chk({tag, " rst data"},   32'(dout),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, " idle ready0"}, 32'(ready0), 32'd0);
    chk({tag, " idle ready1"}, 32'(ready1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    row     = 0;
    rst     = 1'b1;
    req0    = 1'b1;
    data0   = 8'h11;
    req1    = 1'b0;
    data1   = 8'h00;
    rdy     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("init ready0", 32'(ready0), 32'd0);
    chk("init ready1", 32'(ready1), 32'd0);
    chk("init sel",    32'(sel),    32'd0);
    chk("init valid",  32'(valid),  32'd0);
    chk("init data",   32'(dout),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init idle ready0", 32'(ready0), 32'd0);

    // Port 0 alone, three beats, then release.
    cyc(H, 8'h11, L, 8'h00, H,  H, L, L, L, 8'h00);
    cyc(H, 8'h22, L, 8'h00, H,  H, L, L, H, 8'h11);
    cyc(H, 8'h33, L, 8'h00, H,  H, L, L, H, 8'h22);
    cyc(L, 8'h00, L, 8'h00, H,  H, L, L, H, 8'h33);
    cyc(H, 8'hA0, H, 8'hB0, H,  L, L, L, L, 8'h33);
    do_reset("r1");

    // Both requesting from reset: four beats each, hand-over without a bubble.
    cyc(H, 8'hA0, H, 8'hB0, H,  H, L, L, L, 8'h00);
    cyc(H, 8'hA1, H, 8'hB0, H,  H, L, L, H, 8'hA0);
    cyc(H, 8'hA2, H, 8'hB0, H,  H, L, L, H, 8'hA1);
    cyc(H, 8'hA3, H, 8'hB0, H,  H, L, L, H, 8'hA2);
    cyc(H, 8'hA4, H, 8'hB0, H,  L, H, H, H, 8'hA3);
    cyc(H, 8'hA4, H, 8'hB1, H,  L, H, H, H, 8'hB0);
    cyc(H, 8'hA4, H, 8'hB2, H,  L, H, H, H, 8'hB1);
    cyc(H, 8'hA4, H, 8'hB3, H,  L, H, H, H, 8'hB2);
    cyc(H, 8'hA4, H, 8'hB4, H,  H, L, L, H, 8'hB3);
    cyc(L, 8'h00, H, 8'hB4, H,  H, L, L, H, 8'hA4);

    // Port 1 stalled by the sink for five cycles, then resumes.
    cyc(L, 8'h00, H, 8'hB4, H,  L, H, H, L, 8'hA4);
    for (int i = 0; i < 5; i++)
      cyc(L, 8'h00, H, 8'hB5, L,  L, L, H, H, 8'hB4);
    cyc(L, 8'h00, H, 8'hB5, H,  L, H, H, H, 8'hB4);
    cyc(L, 8'h00, H, 8'hB6, H,  L, H, H, H, 8'hB5);
    cyc(L, 8'h00, L, 8'h00, H,  L, H, H, H, 8'hB6);
    cyc(L, 8'h00, L, 8'h00, H,  L, L, H, L, 8'hB6);

    // Port 0 drops after two beats; port 1 then gets a fresh full quantum.
    cyc(H, 8'hC0, H, 8'hD0, H,  L, L, H, L, 8'hB6);
    cyc(H, 8'hC0, H, 8'hD0, H,  H, L, L, L, 8'hB6);
    cyc(H, 8'hC1, H, 8'hD0, H,  H, L, L, H, 8'hC0);
    cyc(L, 8'h00, H, 8'hD0, H,  H, L, L, H, 8'hC1);
    cyc(H, 8'hC2, H, 8'hD0, H,  L, H, H, L, 8'hC1);
    cyc(H, 8'hC2, H, 8'hD1, H,  L, H, H, H, 8'hD0);
    cyc(H, 8'hC2, H, 8'hD2, H,  L, H, H, H, 8'hD1);
    cyc(H, 8'hC2, H, 8'hD3, H,  L, H, H, H, 8'hD2);
    cyc(H, 8'hC2, L, 8'h00, H,  H, L, L, H, 8'hD3);
    cyc(L, 8'h00, L, 8'h00, H,  H, L, L, H, 8'hC2);
    cyc(L, 8'h00, H, 8'hE0, H,  L, L, L, L, 8'hC2);

    // Port 1 alone for nine beats: quantum wraps, ready never drops.
    cyc(L, 8'h00, H, 8'hE0, H,  L, H, H, L, 8'hC2);
    for (int i = 0; i < 8; i++)
      cyc(L, 8'h00, H, 8'hE1 + 8'(i), H,  L, H, H, H, 8'hE0 + 8'(i));
    cyc(L, 8'h00, L, 8'h00, H,  L, H, H, H, 8'hE8);

    // Last grant went to port 1, so a tie from IDLE favours port 0.
    cyc(H, 8'hF0, H, 8'h5A, H,  L, L, H, L, 8'hE8);
    cyc(H, 8'hF0, H, 8'h5A, H,  H, L, L, L, 8'hE8);
    cyc(H, 8'hF1, H, 8'h5A, L,  L, L, L, H, 8'hF0);

    // Reset while a beat is held; the tie pointer must return to port 0.
    do_reset("r2");
    cyc(L, 8'h00, L, 8'h00, H,  H, L, L, L, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
